beta_fetch: RTL and testbench
=============================

BETA_FETCH -- requirements
Module: beta_fetch

Interface
REQ-001 SHALL have one clock and one synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL provide the instruction-memory side ports:
- imem_req out 1: fetch request.
- imem_addr out 32: fetch address, word aligned.
- imem_ack in 1: data valid this cycle.
- imem_rdata in 32: instruction word.
REQ-003 SHALL provide the control-decoder side ports:
- instr out 32: held instruction.
- op out 6: instr[31:26].
- instr_valid out 1: instr is live for decode.
- irq_req out 1: interrupt being taken on this instruction.
REQ-004 SHALL provide the execute side ports:
- advance in 1: current instruction commits this cycle.
- pcsel in 3: next-PC select from decoder.
- jt in 32: jump target, register-file read port 1.
- irq in 1: external interrupt, level.
REQ-005 SHALL provide the PC outputs: pc out 32, address of the held instruction; pc_plus4 out 32, pc+4 for link/XP writeback.

Function
REQ-006 SHALL implement a three-state FSM. RST: entered from reset, lasts one cycle, then goes to FETCH. FETCH: imem_req=1, waits for imem_ack. HOLD: instr_valid=1, waits for advance.
REQ-007 In FETCH, imem_addr SHALL equal pc and SHALL stay stable until imem_ack. An ack in the same cycle as req counts.
REQ-008 On imem_ack in FETCH, SHALL capture imem_rdata into instr and enter HOLD the next cycle. Latency from ack to instr_valid is one cycle.
REQ-009 SHALL ignore imem_ack outside FETCH and advance outside HOLD.
REQ-010 On advance in HOLD, SHALL load pc with the selected next PC and enter FETCH the next cycle.
REQ-011 Next-PC selection, all 32-bit arithmetic with modulo wrap on bits [30:0]:
- pcsel 0: pc+4, bit 31 preserved.
- pcsel 1: pc+4+4*sext(instr[15:0]), bit 31 forced to old pc[31].
- pcsel 2: {pc[31]&jt[31], jt[30:2], 2'b00}; a jump can clear supervisor but never set it.
- pcsel 3: 0x80000004 (ILLOP).
- pcsel 4: 0x80000008 (XADR).
- pcsel 5-7: treated as 3.
REQ-012 pc_plus4 SHALL be {pc[31], pc[30:0]+4} at all times.
REQ-013 SHALL latch irq into irq_pend on any cycle it is high. irq_pend SHALL clear only when the interrupt is taken or on reset.
REQ-014 irq_req SHALL equal irq_pend & ~pc[31] & (state==HOLD). Supervisor mode is never interrupted.
REQ-015 On advance with irq_req=1, next PC SHALL be 0x80000008 regardless of pcsel, and irq_pend SHALL clear that cycle.
REQ-016 If irq rises in the same cycle it is taken, irq_pend SHALL stay set, so a level interrupt is not lost.
REQ-017 instr, op and pc SHALL remain stable throughout HOLD.

Reset
REQ-018 While reset=1, the FSM SHALL be in RST, with pc=0x80000000, instr=0, instr_valid=0, imem_req=0, irq_pend=0 and irq_req=0.
REQ-019 Reset asserted mid-fetch SHALL abandon the request. A late imem_ack SHALL be ignored, and fetch restarts at 0x80000000 one cycle after reset deasserts.

Configuration
REQ-020 With BETA_FETCH_IRQ_EN defined, the interrupt logic of REQ-013..016 SHALL be present.
REQ-021 Without BETA_FETCH_IRQ_EN, irq SHALL be ignored, irq_pend SHALL be absent, and irq_req SHALL be constant 0.

Verification
REQ-022 Reset release -> imem_req=1 and imem_addr=0x80000000 within 2 cycles; ack with 0x77FF0000 -> next cycle instr_valid=1 and op=6'h1D.
REQ-023 pc=0x00000100, instr[15:0]=0xFFFE, pcsel=1, advance -> next imem_addr=0x000000FC.
REQ-024 pc=0x80000010, pcsel=2, jt=0x00000203, advance -> imem_addr=0x00000200. With pc=0x00000010 and jt=0x80000200 -> imem_addr=0x00000200, bit 31 not set.
REQ-025 User-mode pc=0x00000040, irq pulse one cycle while in FETCH, ack -> HOLD shows irq_req=1; advance with pcsel=0 -> imem_addr=0x80000008 and irq_req=0 afterwards.
REQ-026 Reset asserted while imem_req=1, ack arrives during reset -> instr stays 0 and the first fetch after release is 0x80000000.
REQ-027 imem_ack delayed 5 cycles -> imem_addr stable for all 5 cycles; pcsel=5 on advance -> imem_addr=0x80000004.

Source files
------------

// File: rtl/beta_fetch.sv
// beta_fetch: Beta instruction fetch unit -- PC register, RST/FETCH/HOLD sequencer, next-PC select.
// Define BETA_FETCH_IRQ_EN to build in the level-sensitive interrupt pend/take logic.
module beta_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic        irq_req,
  input  logic        advance,
  input  logic [2:0]  pcsel,
  input  logic [31:0] jt,
  input  logic        irq,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_HOLD} state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc_inc;
  logic [31:0] br_off;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] sel_pc;
  logic [31:0] pc_d;
  logic        take_irq;

  // Bit 31 is the supervisor flag; arithmetic only ever wraps within [30:0].
  assign pc_inc = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_pc  = {pc_q[31], pc_inc[30:0] + br_off[30:0]};
  assign jmp_pc = {pc_q[31] & jt[31], jt[30:2], 2'b00};

  always_comb begin
    sel_pc = ILLOP_PC;
    case (pcsel)
      3'd0:    sel_pc = pc_inc;
      3'd1:    sel_pc = br_pc;
      3'd2:    sel_pc = jmp_pc;
      3'd4:    sel_pc = XADR_PC;
      default: sel_pc = ILLOP_PC;
    endcase
  end

  assign pc_d = take_irq ? XADR_PC : sel_pc;

`ifdef BETA_FETCH_IRQ_EN
  logic irq_pend_q;
  logic irq_pend_d;

  // A fresh irq in the take cycle wins over the clear so a level request is never dropped.
  assign irq_req    = irq_pend_q & ~pc_q[31] & (state_q == ST_HOLD);
  assign take_irq   = irq_req & advance;
  assign irq_pend_d = irq | (irq_pend_q & ~take_irq);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end
`else
  logic unused_irq;

  assign unused_irq = irq;
  assign irq_req    = 1'b0;
  assign take_irq   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= ST_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            pc_q    <= pc_d;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RST;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;

endmodule

// File: tb/tb_beta_fetch.sv
// tb_beta_fetch: directed fetch/hold sequences with a queue-based scoreboard for beta_fetch.
// Expected interrupt behaviour follows whether BETA_FETCH_IRQ_EN is defined for the build.
module tb_beta_fetch;

`ifdef BETA_FETCH_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        irq;
  } holdT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = '0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instrValid;
  logic        irqReq;
  logic        advance = 1'b0;
  logic [2:0]  pcsel = '0;
  logic [31:0] jt = '0;
  logic        irq = 1'b0;
  logic [31:0] pc;
  logic [31:0] pcPlus4;

  logic [31:0] fetchQ[$];
  holdT        holdQ[$];
  holdT        curHold;
  int          compared = 0;
  int          mismatched = 0;
  int          sinceRel = 0;
  bit          resetPrev = 1'b0;
  bit          prevValid = 1'b0;
  bit          done = 1'b0;
  bit          finished = 1'b0;

  beta_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .instr(instr), .op(op), .instr_valid(instrValid), .irq_req(irqReq),
    .advance(advance), .pcsel(pcsel), .jt(jt), .irq(irq),
    .pc(pc), .pc_plus4(pcPlus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, checks reset values, fetch addresses and held instructions.
  always @(negedge clk) begin
    if (reset) begin
      if (resetPrev) begin
        checkOutput("rstImemReq", {31'd0, imemReq}, 32'd0);
        checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("rstPc", pc, 32'h8000_0000);
        checkOutput("rstInstr", instr, 32'd0);
        checkOutput("rstIrqReq", {31'd0, irqReq}, 32'd0);
      end
      fetchQ.delete();
      sinceRel = 0;
      prevValid = 1'b0;
    end else begin
      if (sinceRel < 3) sinceRel++;
      if (sinceRel == 2) begin
        checkOutput("releaseReq", {31'd0, imemReq}, 32'd1);
        checkOutput("releaseAddr", imemAddr, 32'h8000_0000);
      end
      if (imemReq) begin
        if (fetchQ.size() == 0) begin
          checkOutput("unexpectedFetch", imemAddr, 32'hFFFF_FFFF);
        end else begin
          checkOutput("fetchAddr", imemAddr, fetchQ[0]);
          if (imemAck) void'(fetchQ.pop_front());
        end
      end
      if (instrValid) begin
        if (!prevValid) begin
          if (holdQ.size() == 0) begin
            checkOutput("unexpectedHold", instr, 32'hFFFF_FFFF);
            curHold = '{instr: instr, pc: pc, irq: irqReq};
          end else begin
            curHold = holdQ.pop_front();
          end
        end
        checkOutput("holdInstr", instr, curHold.instr);
        checkOutput("holdOp", {26'd0, op}, {26'd0, curHold.instr[31:26]});
        checkOutput("holdPc", pc, curHold.pc);
        checkOutput("holdPcPlus4", pcPlus4, curHold.pc + 32'd4);
        checkOutput("holdIrqReq", {31'd0, irqReq}, {31'd0, curHold.irq});
      end
      prevValid = instrValid;
    end
    resetPrev = reset;
    if (done && !finished) begin
      checkOutput("fetchQEmpty", fetchQ.size(), 32'd0);
      checkOutput("holdQEmpty", holdQ.size(), 32'd0);
      finished = 1'b1;
    end
  end

  task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] rdata,
                               input int ackDelay, input logic irqPulse, input logic expIrq,
                               input int holdCycles, input logic doAdv,
                               input logic [2:0] sel, input logic [31:0] jtv);
    int n;
    fetchQ.push_back(expAddr);
    holdQ.push_back('{instr: rdata, pc: expAddr, irq: expIrq});
    n = 0;
    while (!imemReq && n < 20) begin
      tick();
      n++;
    end
    if (!imemReq) begin
      $display("[TB] FAIL fetchWait: got imem_req=0 after %0d cycles, expected 1", n);
      $fatal(1, "[TB] fetch request never appeared");
    end
    if (irqPulse) begin
      irq = 1'b1;
      tick();
      irq = 1'b0;
    end
    // advance while fetching must be ignored
    for (int i = 0; i < ackDelay; i++) begin
      advance = 1'b1;
      pcsel = 3'd3;
      tick();
    end
    advance = 1'b0;
    imemAck = 1'b1;
    imemRdata = rdata;
    tick();
    for (int i = 0; i < holdCycles; i++) begin
      imemRdata = 32'hDEAD_BEEF;
      tick();
    end
    imemAck = 1'b0;
    imemRdata = 32'hA5A5_5A5A;
    if (doAdv) begin
      advance = 1'b1;
      pcsel = sel;
      jt = jtv;
      tick();
      advance = 1'b0;
      pcsel = 3'd0;
      jt = '0;
    end
  endtask

  initial begin
    logic [31:0] irqNext;
    int n;
    irqNext = IrqOn ? 32'h8000_0008 : 32'h0000_0044;
    repeat (3) tick();
    reset = 1'b0;
    applyStimulus(32'h8000_0000, 32'h77FF_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h0000_0100);
    applyStimulus(32'h0000_0100, 32'h0000_FFFE, 0, 1'b0, 1'b0, 1, 1'b1, 3'd1, 32'h0);
    applyStimulus(32'h0000_00FC, 32'h1234_5678, 0, 1'b0, 1'b0, 0, 1'b1, 3'd3, 32'h0);
    applyStimulus(32'h8000_0004, 32'h0000_0001, 1, 1'b0, 1'b0, 0, 1'b1, 3'd0, 32'h0);
    applyStimulus(32'h8000_0008, 32'h0000_0002, 0, 1'b0, 1'b0, 0, 1'b1, 3'd0, 32'h0);
    applyStimulus(32'h8000_000C, 32'h0000_0003, 0, 1'b0, 1'b0, 0, 1'b1, 3'd0, 32'h0);
    applyStimulus(32'h8000_0010, 32'hC000_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h0000_0203);
    applyStimulus(32'h0000_0200, 32'h0400_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h0000_0010);
    applyStimulus(32'h0000_0010, 32'h0800_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h8000_0200);
    applyStimulus(32'h0000_0200, 32'h0C00_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h0000_0040);
    applyStimulus(32'h0000_0040, 32'h1000_0000, 0, 1'b1, IrqOn, 1, 1'b1, 3'd0, 32'h0);
    applyStimulus(irqNext, 32'h1400_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd2, 32'h0000_0044);
    applyStimulus(32'h0000_0044, 32'hFC00_1234, 5, 1'b0, 1'b0, 2, 1'b1, 3'd5, 32'h0);
    applyStimulus(32'h8000_0004, 32'h2000_0000, 0, 1'b0, 1'b0, 0, 1'b1, 3'd0, 32'h0);
    // abandon the fetch of 0x80000008 with a reset and a late ack
    fetchQ.push_back(32'h8000_0008);
    tick();
    reset = 1'b1;
    tick();
    imemAck = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    imemAck = 1'b0;
    applyStimulus(32'h8000_0000, 32'h3000_0000, 0, 1'b0, 1'b0, 1, 1'b0, 3'd0, 32'h0);
    done = 1'b1;
    n = 0;
    while (!finished && n < 10) begin
      tick();
      n++;
    end
    if (!finished) begin
      $display("[TB] FAIL monitorDone: got finished=0, expected 1");
      $fatal(1, "[TB] monitor did not complete");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
